// File: rtl/pipe_game_controller_if.sv
// Bundle of game-controller signals between input/physics, controller and renderer.
// master: the controller (drives game outputs). slave: the surrounding logic.
interface pipe_game_controller_if #(
    parameter int unsigned NUM_PIPES = 3,
    parameter int unsigned XW        = 11,
    parameter int unsigned SCORE_W   = 8
);
    logic                   frame_tick;
    logic                   start_button;
    logic [9:0]             bird_y;
    logic [1:0]             state;
    logic [NUM_PIPES*XW-1:0] pipe_x;
    logic [NUM_PIPES*9-1:0] pipe_gap_y;
    logic [SCORE_W-1:0]     score;
    logic                   collision;
    logic                   game_over_pulse;

    modport master (
        input  frame_tick, start_button, bird_y,
        output state, pipe_x, pipe_gap_y, score, collision, game_over_pulse
    );

    modport slave (
        output frame_tick, start_button, bird_y,
        input  state, pipe_x, pipe_gap_y, score, collision, game_over_pulse
    );
endinterface

// File: rtl/pipe_game_controller.sv
// Game-state controller for the pipe-dodging game: IDLE/PLAY/GAME_OVER sequencing,
// pipe movement and wrap, bird/pipe and bird/floor collision, saturating score.
// Optional feature macro: PIPE_RANDOM_GAP_EN (random gap tops from a 16-bit LFSR on wrap);
// when undefined the LFSR is absent and every gap stays at PIPE_GAP_Y_POS.
module pipe_game_controller #(
    parameter int unsigned SCREEN_WIDTH   = 640,
    parameter int unsigned SCREEN_HEIGHT  = 480,
    parameter int unsigned NUM_PIPES      = 3,
    parameter int unsigned PIPE_WIDTH     = 50,
    parameter int unsigned PIPE_GAP       = 100,
    parameter int unsigned PIPE_GAP_Y_POS = 190,
    parameter int unsigned PIPE_SPACING   = 240,
    parameter int unsigned PIPE_SPEED     = 2,
    parameter int unsigned BIRD_X         = 100,
    parameter int unsigned BIRD_WIDTH     = 20,
    parameter int unsigned BIRD_HEIGHT    = 20,
    parameter int unsigned GAP_MIN        = 40,
    parameter int unsigned GAP_RANGE      = 300,
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned XW             = $clog2(SCREEN_WIDTH + NUM_PIPES * PIPE_SPACING)
) (
    input logic                    clk,
    input logic                    reset,
    pipe_game_controller_if.master bus
);

    localparam int unsigned Span     = NUM_PIPES * PIPE_SPACING;
    localparam int unsigned ScoreMax = (32'd1 << SCORE_W) - 32'd1;

    // Elaboration-time parameter sanity checks
    if (NUM_PIPES < 1 || NUM_PIPES > 8) begin : g_chk_pipes
        $error("NUM_PIPES must be 1..8");
    end
    if (PIPE_SPEED < 1 || PIPE_SPEED >= PIPE_SPACING) begin : g_chk_speed
        $error("PIPE_SPEED must be in 1..PIPE_SPACING-1");
    end
    if (GAP_MIN + GAP_RANGE > 512 || GAP_RANGE < 256) begin : g_chk_gap
        $error("GAP_MIN/GAP_RANGE out of the 9-bit gap range");
    end

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StOver = 2'b10
    } state_e;

    state_e             state_q;
    logic               start_d;
    logic [XW-1:0]      pipe_x_q [NUM_PIPES];
    logic [8:0]         gap_q    [NUM_PIPES];
    logic [SCORE_W-1:0] score_q;
    logic               collision_q;
    logic               pulse_q;

    logic                 start_edge;
    logic [NUM_PIPES-1:0] wrap;
    logic [NUM_PIPES-1:0] passed;
    logic [NUM_PIPES-1:0] pipe_hit;
    logic [XW-1:0]        x_next [NUM_PIPES];
    logic                 floor_hit;
    logic                 any_hit;
    int unsigned          pass_cnt;
    int unsigned          score_sum;
    logic [SCORE_W-1:0]   score_next;
    logic [8:0]           new_gap;

    assign start_edge = bus.start_button & ~start_d;

`ifdef PIPE_RANDOM_GAP_EN
    logic [15:0] lfsr_q;
    int unsigned rnd;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Fold the 9-bit draw into GAP_MIN..GAP_MIN+GAP_RANGE-1
    always_comb begin
        rnd     = 32'(lfsr_q[8:0]);
        new_gap = 9'(GAP_MIN + ((rnd >= GAP_RANGE) ? rnd - GAP_RANGE : rnd));
    end
`else
    assign new_gap = 9'(PIPE_GAP_Y_POS);
`endif

    // Per-pipe move/wrap, scoring and collision on pre-move positions
    always_comb begin
        wrap      = '0;
        passed    = '0;
        pipe_hit  = '0;
        pass_cnt  = 0;
        floor_hit = (32'(bus.bird_y) + BIRD_HEIGHT) > SCREEN_HEIGHT;
        for (int i = 0; i < NUM_PIPES; i++) begin
            wrap[i]   = 32'(pipe_x_q[i]) < PIPE_SPEED;
            x_next[i] = wrap[i] ? XW'(32'(pipe_x_q[i]) + Span - PIPE_SPEED)
                                : XW'(32'(pipe_x_q[i]) - PIPE_SPEED);
            // Right edge crosses BIRD_X during this move; a wrapping pipe never counts
            passed[i] = !wrap[i]
                     && (32'(pipe_x_q[i]) + PIPE_WIDTH >= BIRD_X)
                     && (32'(pipe_x_q[i]) + PIPE_WIDTH - PIPE_SPEED < BIRD_X);
            pipe_hit[i] = (32'(pipe_x_q[i]) < BIRD_X + BIRD_WIDTH)
                       && (32'(pipe_x_q[i]) + PIPE_WIDTH > BIRD_X)
                       && ((32'(bus.bird_y) < 32'(gap_q[i]))
                           || (32'(bus.bird_y) + BIRD_HEIGHT > 32'(gap_q[i]) + PIPE_GAP));
            if (passed[i]) begin
                pass_cnt = pass_cnt + 1;
            end
        end
        any_hit    = floor_hit | (|pipe_hit);
        score_sum  = 32'(score_q) + pass_cnt;
        score_next = (score_sum > ScoreMax) ? SCORE_W'(ScoreMax) : SCORE_W'(score_sum);
    end

    // Game FSM with pipe, score and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            start_d     <= 1'b0;
            score_q     <= '0;
            collision_q <= 1'b0;
            pulse_q     <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_q[i] <= XW'(SCREEN_WIDTH + 32'(i) * PIPE_SPACING);
                gap_q[i]    <= 9'(PIPE_GAP_Y_POS);
            end
        end else begin
            start_d <= bus.start_button;
            pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q <= StPlay;
                        score_q <= '0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            pipe_x_q[i] <= XW'(SCREEN_WIDTH + 32'(i) * PIPE_SPACING);
                            gap_q[i]    <= 9'(PIPE_GAP_Y_POS);
                        end
                    end
                end
                StPlay: begin
                    if (bus.frame_tick) begin
                        if (any_hit) begin
                            // Collision wins: freeze pipes and score
                            state_q     <= StOver;
                            collision_q <= 1'b1;
                            pulse_q     <= 1'b1;
                        end else begin
                            score_q <= score_next;
                            for (int i = 0; i < NUM_PIPES; i++) begin
                                pipe_x_q[i] <= x_next[i];
                                if (wrap[i]) begin
                                    gap_q[i] <= new_gap;
                                end
                            end
                        end
                    end
                end
                StOver: begin
                    if (start_edge) begin
                        state_q     <= StIdle;
                        collision_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.state           = state_q;
    assign bus.score           = score_q;
    assign bus.collision       = collision_q;
    assign bus.game_over_pulse = pulse_q;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
        assign bus.pipe_x[g*XW +: XW]   = pipe_x_q[g];
        assign bus.pipe_gap_y[g*9 +: 9] = gap_q[g];
    end

endmodule

// File: tb/tb_pipe_game_controller.sv
// Scoreboard bench for pipe_game_controller: stimulus pushes cycle-tagged expectations,
// a monitor pops and compares them one time-step after each rising clock edge.
module tb_pipe_game_controller;

    localparam int NP = 3;
    localparam int XWB = 11;

    logic clk;
    logic reset;
    logic steer;
    logic [9:0] bird_stim;
    logic [9:0] steer_y;

    pipe_game_controller_if #(.NUM_PIPES(NP), .XW(XWB), .SCORE_W(8)) bus ();

    pipe_game_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.bird_y = steer ? steer_y : bird_stim;

    typedef struct {
        int cyc;
        int id;
        int idx;
        int val;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int actual(int id, int idx);
        case (id)
            0: return int'(bus.state);
            1: return int'(bus.pipe_x[idx*XWB +: XWB]);
            2: return int'(bus.pipe_gap_y[idx*9 +: 9]);
            3: return int'(bus.score);
            4: return int'(bus.collision);
            default: return int'(bus.game_over_pulse);
        endcase
    endfunction

    function automatic string sig_name(int id);
        case (id)
            0: return "state";
            1: return "pipe_x";
            2: return "pipe_gap_y";
            3: return "score";
            4: return "collision";
            default: return "game_over_pulse";
        endcase
    endfunction

    // Monitor: compare every expectation due at this cycle
    initial begin
        exp_t e;
        int act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                act = actual(e.id, e.idx);
                total++;
                if (act != e.val) begin
                    bad++;
                    $display("FAIL %s[%0d] cycle=%0d got=%0d expected=%0d",
                             sig_name(e.id), e.idx, cyc, act, e.val);
                end
            end
        end
    end

    // Stimulus-side bird steering for long runs: aim into the gap of the pipe near the bird
    always @(negedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (int'(bus.pipe_x[i*XWB +: XWB]) > 30 && int'(bus.pipe_x[i*XWB +: XWB]) < 140) begin
                steer_y <= 10'(int'(bus.pipe_gap_y[i*9 +: 9]) + 40);
            end
        end
    end

    task automatic exp_at(int d, int id, int idx, int val);
        q.push_back('{cyc + d, id, idx, val});
    endtask

    task automatic exp_pipes(int d, int a, int b, int c);
        exp_at(d, 1, 0, a);
        exp_at(d, 1, 1, b);
        exp_at(d, 1, 2, c);
    endtask

    task automatic drive(logic ft, logic st);
        @(negedge clk);
        bus.frame_tick   = ft;
        bus.start_button = st;
    endtask

    task automatic tick_n(int n);
        repeat (n) begin
            drive(1'b1, 1'b0);
            drive(1'b0, 1'b0);
        end
    endtask

    // n back-to-back ticks, one per clock
    task automatic burst(int n);
        drive(1'b1, 1'b0);
        repeat (n - 1) @(negedge clk);
        drive(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_at(1, 0, 0, 0);
        exp_at(1, 5, 0, 0);
        exp_at(1, 4, 0, 0);
        exp_at(1, 3, 0, 0);
        exp_pipes(1, 640, 880, 1120);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        steer            = 1'b0;
        steer_y          = 10'd230;
        bird_stim        = 10'd195;
        bus.frame_tick   = 1'b0;
        bus.start_button = 1'b0;

        // Reset values
        @(negedge clk);
        exp_at(1, 0, 0, 0);
        exp_pipes(1, 640, 880, 1120);
        for (int i = 0; i < NP; i++) exp_at(1, 2, i, 190);
        exp_at(1, 3, 0, 0);
        exp_at(1, 4, 0, 0);
        exp_at(1, 5, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Tick in IDLE is ignored
        drive(1'b1, 1'b0);
        exp_at(1, 0, 0, 0);
        exp_at(1, 1, 0, 640);
        drive(1'b0, 1'b0);

        // Start held for 10 cycles: single entry into PLAY
        drive(1'b0, 1'b1);
        exp_at(1, 0, 0, 1);
        exp_pipes(1, 640, 880, 1120);
        exp_at(1, 3, 0, 0);
        repeat (9) @(negedge clk);
        exp_at(1, 0, 0, 1);
        drive(1'b0, 1'b0);

        // Safe bird: first point after tick 296
        tick_n(295);
        drive(1'b1, 1'b0);
        exp_at(1, 1, 0, 48);
        exp_at(1, 3, 0, 1);
        exp_at(1, 4, 0, 0);
        exp_at(1, 0, 0, 1);
        drive(1'b0, 1'b0);

        // Pipe 0 reaches 0 at tick 320, wraps to 718 at tick 321
        tick_n(23);
        drive(1'b1, 1'b0);
        exp_pipes(1, 0, 240, 480);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        exp_pipes(1, 718, 238, 478);
        exp_at(1, 3, 0, 1);
`ifndef PIPE_RANDOM_GAP_EN
        exp_at(1, 2, 0, 190);
`endif
        drive(1'b0, 1'b0);

        // Reset mid-game
        do_reset();

        // Pipe collision at tick 262 (pre-move x = 118)
        bird_stim = 10'd100;
        drive(1'b0, 1'b1);
        exp_at(1, 0, 0, 1);
        drive(1'b0, 1'b0);
        tick_n(260);
        drive(1'b1, 1'b0);
        exp_at(1, 0, 0, 1);
        exp_at(1, 1, 0, 118);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        exp_at(1, 0, 0, 2);
        exp_at(1, 4, 0, 1);
        exp_at(1, 5, 0, 1);
        exp_pipes(1, 118, 358, 598);
        exp_at(1, 3, 0, 0);
        exp_at(2, 5, 0, 0);
        exp_at(2, 0, 0, 2);
        drive(1'b0, 1'b0);
        tick_n(3);
        drive(1'b1, 1'b0);
        exp_at(1, 1, 0, 118);
        exp_at(1, 0, 0, 2);
        drive(1'b0, 1'b0);

        // GAME_OVER -> IDLE holds pipes
        drive(1'b0, 1'b1);
        exp_at(1, 0, 0, 0);
        exp_at(1, 4, 0, 0);
        exp_at(1, 1, 0, 118);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        exp_at(1, 1, 0, 118);
        exp_at(1, 0, 0, 0);
        drive(1'b0, 1'b0);

        // Start coincident with a tick: tick ignored, pipes reloaded
        drive(1'b1, 1'b1);
        exp_at(1, 0, 0, 1);
        exp_pipes(1, 640, 880, 1120);
        exp_at(1, 3, 0, 0);
        drive(1'b0, 1'b0);

        // Floor collision on the first moving tick
        bird_stim = 10'd461;
        drive(1'b1, 1'b0);
        exp_at(1, 0, 0, 2);
        exp_at(1, 4, 0, 1);
        exp_at(1, 5, 0, 1);
        exp_pipes(1, 640, 880, 1120);
        exp_at(1, 3, 0, 0);
        drive(1'b0, 1'b0);

        // Long run to score saturation with a steered bird
        do_reset();
        bird_stim = 10'd230;
        drive(1'b0, 1'b1);
        exp_at(1, 0, 0, 1);
        drive(1'b0, 1'b0);
        steer = 1'b1;
        burst(30774);
        drive(1'b1, 1'b0);
        exp_at(1, 3, 0, 254);
        drive(1'b1, 1'b0);
        exp_at(1, 3, 0, 255);
        drive(1'b0, 1'b0);
        burst(240);
        drive(1'b1, 1'b0);
        exp_at(1, 3, 0, 255);
        exp_at(1, 0, 0, 1);
        exp_at(1, 4, 0, 0);
        drive(1'b0, 1'b0);
        @(negedge clk);
`ifdef PIPE_RANDOM_GAP_EN
        for (int i = 0; i < NP; i++) begin
            total++;
            if (int'(bus.pipe_gap_y[i*9 +: 9]) < 40 || int'(bus.pipe_gap_y[i*9 +: 9]) > 339) begin
                bad++;
                $display("FAIL gap_range[%0d] got=%0d expected=40..339", i,
                         int'(bus.pipe_gap_y[i*9 +: 9]));
            end
        end
`else
        for (int i = 0; i < NP; i++) exp_at(1, 2, i, 190);
`endif
        steer = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s[%0d] got=never-checked expected=%0d", sig_name(e.id), e.idx, e.val);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
